// File: rtl/carry_lookahead_adder_pkg.sv
// Shared helpers for the carry-lookahead adder.
package carry_lookahead_adder_pkg;

    function automatic int cla_num_groups(input int width, input int grp_w);
        return (width + grp_w - 1) / grp_w;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit lookahead group: local carries, sums and group generate/propagate.
module cla_group4
    import carry_lookahead_adder_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       g,
    output logic       p
);

    logic [3:0] bit_g;
    logic [3:0] bit_p;
    logic [3:0] c;

    always_comb begin
        bit_g = a & b;
        bit_p = a ^ b;
        // every carry is a flat function of this group's g/p and cin
        c[0] = cin;
        c[1] = bit_g[0]
             | (bit_p[0] & cin);
        c[2] = bit_g[1]
             | (bit_p[1] & bit_g[0])
             | (bit_p[1] & bit_p[0] & cin);
        c[3] = bit_g[2]
             | (bit_p[2] & bit_g[1])
             | (bit_p[2] & bit_p[1] & bit_g[0])
             | (bit_p[2] & bit_p[1] & bit_p[0] & cin);
        s = bit_p ^ c;
        g = bit_g[3]
          | (bit_p[3] & bit_g[2])
          | (bit_p[3] & bit_p[2] & bit_g[1])
          | (bit_p[3] & bit_p[2] & bit_p[1] & bit_g[0]);
        p = &bit_p;
    end

endmodule

// File: rtl/carry_lookahead_adder.sv
// Unsigned carry-lookahead adder, WIDTH+1-bit sum plus a registered copy.
module carry_lookahead_adder
    import carry_lookahead_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    output logic [WIDTH:0]   o_result,
    output logic [WIDTH:0]   o_result_q
);

    localparam int GROUP_W    = 4;
    localparam int NUM_GROUPS = cla_num_groups(WIDTH, GROUP_W);
    localparam int PAD_W      = NUM_GROUPS * GROUP_W;

    logic [PAD_W-1:0]      a_pad;
    logic [PAD_W-1:0]      b_pad;
    logic [PAD_W-1:0]      sum_pad;
    logic [PAD_W:0]        sum_full;
    logic [NUM_GROUPS-1:0] grp_g;
    logic [NUM_GROUPS-1:0] grp_p;
    logic [NUM_GROUPS:0]   grp_c;
    logic [WIDTH:0]        result_d;
    logic [WIDTH:0]        result_q;

    // zero padding gives g=p=0 above WIDTH, so bit WIDTH of the
    // padded sum is exactly the carry into that position
    always_comb begin
        a_pad = '0;
        b_pad = '0;
        a_pad[WIDTH-1:0] = i_add1;
        b_pad[WIDTH-1:0] = i_add2;
    end

    for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_grp
        cla_group4 u_grp (
            .a   (a_pad[k*GROUP_W +: GROUP_W]),
            .b   (b_pad[k*GROUP_W +: GROUP_W]),
            .cin (grp_c[k]),
            .s   (sum_pad[k*GROUP_W +: GROUP_W]),
            .g   (grp_g[k]),
            .p   (grp_p[k])
        );
    end

    always_comb begin
        grp_c[0] = 1'b0;
        for (int k = 0; k < NUM_GROUPS; k++) begin
            grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
        end
        sum_full = {grp_c[NUM_GROUPS], sum_pad};
        result_d = sum_full[WIDTH:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign o_result   = result_d;
    assign o_result_q = result_q;

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Directed and exhaustive checks of the adder at WIDTH 3, 5, 6 and 8.
module tb_carry_lookahead_adder;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] pa;
    logic [7:0] pb;
    logic [3:0] o3, q3;
    logic [5:0] o5, q5;
    logic [6:0] o6, q6;
    logic [8:0] o8, q8;
    int         n_tests;
    int         n_fail;

    carry_lookahead_adder #(.WIDTH(3)) u_w3 (
        .i_clk(clk), .i_rst(rst), .i_add1(a[2:0]), .i_add2(b[2:0]),
        .o_result(o3), .o_result_q(q3)
    );
    carry_lookahead_adder #(.WIDTH(5)) u_w5 (
        .i_clk(clk), .i_rst(rst), .i_add1(a[4:0]), .i_add2(b[4:0]),
        .o_result(o5), .o_result_q(q5)
    );
    carry_lookahead_adder #(.WIDTH(6)) u_w6 (
        .i_clk(clk), .i_rst(rst), .i_add1(a[5:0]), .i_add2(b[5:0]),
        .o_result(o6), .o_result_q(q6)
    );
    carry_lookahead_adder #(.WIDTH(8)) u_w8 (
        .i_clk(clk), .i_rst(rst), .i_add1(a), .i_add2(b),
        .o_result(o8), .o_result_q(q8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sum_w(input int w, input logic [7:0] x,
                                 input logic [7:0] y);
        int mask;
        mask = (1 << w) - 1;
        return (int'(x) & mask) + (int'(y) & mask);
    endfunction

    task automatic check_q(input logic [7:0] x, input logic [7:0] y);
        check("w3_q", 32'(q3), sum_w(3, x, y));
        check("w5_q", 32'(q5), sum_w(5, x, y));
        check("w6_q", 32'(q6), sum_w(6, x, y));
        check("w8_q", 32'(q8), sum_w(8, x, y));
    endtask

    // drive on falling edge, check comb output and one-cycle lag before
    // the rising edge, then the freshly loaded register after it
    task automatic step(input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        a = x;
        b = y;
        #2;
        check("w3_sum", 32'(o3), sum_w(3, x, y));
        check("w5_sum", 32'(o5), sum_w(5, x, y));
        check("w6_sum", 32'(o6), sum_w(6, x, y));
        check("w8_sum", 32'(o8), sum_w(8, x, y));
        check_q(pa, pb);
        @(posedge clk);
        pa = x;
        pb = y;
        #1;
        check_q(x, y);
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        a = '0;
        b = '0;
        pa = '0;
        pb = '0;
        n_tests = 0;
        n_fail = 0;
        #1 rst = 1'b1;
        #1 check_q(8'd0, 8'd0);
        @(posedge clk);
        #1 check_q(8'd0, 8'd0);
        #1 rst = 1'b0;

        step(8'd0, 8'd1);
        step(8'd2, 8'd2);
        step(8'd5, 8'd6);
        step(8'd255, 8'd1);
        step(8'd255, 8'd255);
        step(8'd0, 8'd0);
        step(8'd7, 8'd7);

        // asynchronous reset between edges with 7+7 held
        #2 rst = 1'b1;
        #1;
        check("rst_w3_q", 32'(q3), 32'd0);
        check("rst_w8_q", 32'(q8), 32'd0);
        check("rst_w3_sum", 32'(o3), 32'd14);
        check("rst_w8_sum", 32'(o8), 32'd14);
        rst = 1'b0;
        pa = '0;
        pb = '0;
        step(8'd7, 8'd7);

        for (int i = 0; i < 65536; i++) begin
            step(8'(i >> 8), 8'(i & 255));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
